shift_seq32: RTL



---
 rtl/shift_seq32.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/shift_seq32.sv
// shift_seq32 - multi-cycle 32-bit shift sequencer.
//
// A shift request of 0..31 positions is split into steps of at most three
// positions. One step is taken per clock through a 4-way-per-bit step
// shifter, so only a 2-bit select mux sits in front of each result bit
// instead of a full five-level barrel shifter.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   op_start  request strobe, sampled only in IDLE
//   op        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   d_in      operand, captured on acceptance
//   shamt     shift amount 0..31, captured on acceptance
//   busy      high whenever the sequencer is not IDLE
//   done      one-cycle completion pulse
//   d_out     result register
//   c_out     last bit shifted out (ROR: final d_out[31])
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for op_start; result registers hold the last result
// SHIFT | one step of min(rem,3) positions per clock
// DONE  | done pulse for one cycle, then back to IDLE

module shift_seq32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic [1:0]  op,
    input  logic [31:0] d_in,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] d_out,
    output logic        c_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [4:0]  r_rem;
    logic [31:0] r_acc;
    logic        r_c;
    logic        r_busy;
    logic        r_done;

    logic [1:0]  w_step;
    logic [31:0] w_acc_nxt;
    logic        w_c_nxt;

    // Step is min(rem,3); never exceeds rem, so rem cannot underflow.
    assign w_step = (r_rem >= 5'd3) ? 2'd3 : r_rem[1:0];

    // Step shifter. For every right-going op the last vacated bit is
    // acc[step-1]; for ROR that same bit lands in the new acc[31].
    always_comb begin
        w_acc_nxt = r_acc;
        w_c_nxt   = 1'b0;
        case (w_step)
            2'd1: begin
                case (r_op)
                    OP_LSL:  w_acc_nxt = {r_acc[30:0], 1'b0};
                    OP_LSR:  w_acc_nxt = {1'b0, r_acc[31:1]};
                    OP_ASR:  w_acc_nxt = {r_acc[31], r_acc[31:1]};
                    default: w_acc_nxt = {r_acc[0], r_acc[31:1]};
                endcase
                w_c_nxt = (r_op == OP_LSL) ? r_acc[31] : r_acc[0];
            end
            2'd2: begin
                case (r_op)
                    OP_LSL:  w_acc_nxt = {r_acc[29:0], 2'b00};
                    OP_LSR:  w_acc_nxt = {2'b00, r_acc[31:2]};
                    OP_ASR:  w_acc_nxt = {{2{r_acc[31]}}, r_acc[31:2]};
                    default: w_acc_nxt = {r_acc[1:0], r_acc[31:2]};
                endcase
                w_c_nxt = (r_op == OP_LSL) ? r_acc[30] : r_acc[1];
            end
            2'd3: begin
                case (r_op)
                    OP_LSL:  w_acc_nxt = {r_acc[28:0], 3'b000};
                    OP_LSR:  w_acc_nxt = {3'b000, r_acc[31:3]};
                    OP_ASR:  w_acc_nxt = {{3{r_acc[31]}}, r_acc[31:3]};
                    default: w_acc_nxt = {r_acc[2:0], r_acc[31:3]};
                endcase
                w_c_nxt = (r_op == OP_LSL) ? r_acc[29] : r_acc[2];
            end
            default: begin
                w_acc_nxt = r_acc;
                w_c_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_op    <= 2'b00;
            r_rem   <= 5'd0;
            r_acc   <= 32'd0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_start) begin
                        r_acc  <= d_in;
                        r_op   <= op;
                        r_rem  <= shamt;
                        r_c    <= 1'b0;
                        r_busy <= 1'b1;
                        if (shamt == 5'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_done  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= r_rem - {3'b000, w_step};
                    r_c   <= w_c_nxt;
                    if (r_rem == {3'b000, w_step}) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign d_out = r_acc;
    assign c_out = r_c;

endmodule
